// File: rtl/cnt8_timer_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : cnt8_timer_ctrl_if
//  Description : Bundle between the interval-timer controller, the user logic
//                that starts/stops it and the attached loadable up-counter.
//  Revision    : 1.0  initial release
// ============================================================================
interface cnt8_timer_ctrl_if #(
    parameter int W = 8
);
    // Control from the surrounding logic
    logic         start;
    logic         stop;
    logic         mode;
    logic [W-1:0] len;

    // Counter observation
    logic [W-1:0] cnt_q;
    logic         cnt_co;

    // Counter drive
    logic         cnt_ld;
    logic [W-1:0] cnt_d;
    logic         cnt_ci;

    // Status back to the surrounding logic
    logic         busy;
    logic         tick;
    logic         done;
    logic [W-1:0] remain;
    logic [W-1:0] exp_cnt;

    // Controller side
    modport slave (
        input  start, stop, mode, len, cnt_q, cnt_co,
        output cnt_ld, cnt_d, cnt_ci, busy, tick, done, remain, exp_cnt
    );

    // Environment side (user logic plus counter)
    modport master (
        output start, stop, mode, len, cnt_q, cnt_co,
        input  cnt_ld, cnt_d, cnt_ci, busy, tick, done, remain, exp_cnt
    );
endinterface
`default_nettype wire

// File: rtl/cnt8_timer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : cnt8_timer_ctrl
//  Description : Sequencing controller that turns a W-bit loadable up-counter
//                into a programmable interval timer (one-shot / periodic).
//                The counter is preloaded with the two's complement of the
//                interval length so that its carry-out marks interval end.
//  Revision    : 1.0  initial release
// ============================================================================
module cnt8_timer_ctrl #(
    parameter int W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    cnt8_timer_ctrl_if.slave      bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

    localparam logic [W-1:0] c_ZERO = '0;
    localparam logic [W-1:0] c_ONE  = {{(W-1){1'b0}}, 1'b1};

    // Registered state
    state_t       state_q,   state_d;
    logic         mode_q,    mode_d;
    logic [W-1:0] len_q,     len_d;
    logic         tick_q,    tick_d;
    logic         done_q,    done_d;
    logic [W-1:0] exp_cnt_q, exp_cnt_d;

    // Combinational drive
    logic [W-1:0] w_reload;
    logic         w_cnt_ld;
    logic         w_cnt_ci;
    logic [W-1:0] w_remain;

    // Preload value: counter hits all-ones after exactly len_q enabled
    // cycles; len_q = 0 naturally yields a full 2^W interval.
    assign w_reload = c_ZERO - len_q;

    // Next-state and counter-drive decode
    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        len_d     = len_q;
        exp_cnt_d = exp_cnt_q;
        tick_d    = 1'b0;
        done_d    = 1'b0;
        w_cnt_ld  = 1'b0;
        w_cnt_ci  = 1'b0;
        w_remain  = c_ZERO;

        case (state_q)
            ST_IDLE: begin
                // stop dominates a simultaneous start; nothing is latched
                if (bus.start && !bus.stop) begin
                    len_d     = bus.len;
                    mode_d    = bus.mode;
                    exp_cnt_d = c_ZERO;
                    state_d   = ST_LOAD;
                end
            end

            ST_LOAD: begin
                w_cnt_ld = 1'b1;
                // Whole interval still ahead while the preload happens
                w_remain = len_q;
                state_d  = bus.stop ? ST_IDLE : ST_RUN;
            end

            ST_RUN: begin
                w_cnt_ci = !bus.stop;
                w_remain = c_ZERO - bus.cnt_q;
                if (bus.stop) begin
                    // Abort wins even over a coincident carry: no tick/done
                    state_d = ST_IDLE;
                end else if (bus.cnt_co) begin
                    tick_d    = 1'b1;
                    exp_cnt_d = exp_cnt_q + c_ONE;
                    if (mode_q) begin
                        // Reload on the carry cycle so the period has no gap
                        w_cnt_ld = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered pulse/status flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            len_q     <= c_ZERO;
            tick_q    <= 1'b0;
            done_q    <= 1'b0;
            exp_cnt_q <= c_ZERO;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            len_q     <= len_d;
            tick_q    <= tick_d;
            done_q    <= done_d;
            exp_cnt_q <= exp_cnt_d;
        end
    end

    // Output mapping; load data is held at zero when not loading
    always_comb begin
        bus.cnt_ld  = w_cnt_ld;
        bus.cnt_d   = w_cnt_ld ? w_reload : c_ZERO;
        bus.cnt_ci  = w_cnt_ci;
        bus.busy    = (state_q == ST_LOAD) || (state_q == ST_RUN);
        bus.remain  = w_remain;
        bus.tick    = tick_q;
        bus.done    = done_q;
        bus.exp_cnt = exp_cnt_q;
    end

endmodule
`default_nettype wire

// File: doc/cnt8_timer_ctrl.md
Name: cnt8_timer_ctrl

Overview:
- Sequencing controller for the team's 8-bit loadable up-counter (cnt8: ld, d, ci in; q, co out).
- Turns the counter into a programmable interval timer with one-shot and periodic modes.
- Drives the counter's ld/d/ci, watches co/q, and reports busy, tick, done, remaining cycles and an expiry count to the surrounding logic.

Parameters:
- W, 8, counter and length width; must match the attached counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  begin an interval of len cycles; sampled only in IDLE.
- stop  in  1  abort; return to IDLE.
- mode  in  1  0 = one-shot, 1 = periodic; latched with start.
- len  in  W  interval length in cycles; 0 means 2^W (256); latched with start.
- cnt_q  in  W  counter value.
- cnt_co  in  1  counter carry-out; high when cnt_ci=1 and cnt_q=all ones.
- cnt_ld  out  1  counter synchronous load.
- cnt_d  out  W  counter load value.
- cnt_ci  out  1  counter count enable.
- busy  out  1  high in LOAD or RUN.
- tick  out  1  one-cycle pulse per completed interval.
- done  out  1  one-cycle pulse when a one-shot interval completes.
- remain  out  W  cycles left in the current interval; 0 in IDLE.
- exp_cnt  out  W  number of completed intervals since start; wraps modulo 2^W.

Behaviour:
- Counter contract: ld has priority over ci; when ci=1 and q=all ones, q wraps to 0 and co=1 in that cycle.
- Reset (async, immediate): state=IDLE, mode_r=0, len_r=0, tick=0, done=0, exp_cnt=0. Combinational outputs therefore read cnt_ld=0, cnt_ci=0, cnt_d=0, busy=0, remain=0.
- Load value: reload = (2^W - len_r) mod 2^W, i.e. two's complement of len_r. From reload the counter reaches all ones after exactly len_r enabled cycles (256 when len_r=0).
- States: IDLE, LOAD, RUN. Outputs are combinational from state and inputs unless marked registered.
- IDLE:
  - cnt_ld=0, cnt_ci=0.
  - start=1 and stop=0: latch len_r=len and mode_r=mode, clear exp_cnt, go to LOAD.
  - start=1 and stop=1 together: stop wins; stay in IDLE and latch nothing.
- LOAD (exactly 1 cycle):
  - cnt_ld=1, cnt_d=reload, cnt_ci=0.
  - stop=1: go to IDLE. Otherwise go to RUN.
- RUN:
  - cnt_ci = !stop; remain = 0 - cnt_q (mod 2^W).
  - When cnt_co=1 and stop=0:
    - tick is set (registered) and exp_cnt increments; both visible the next cycle.
    - mode_r=1: cnt_ld=1 and cnt_d=reload in the same cycle. The counter restarts with no gap, so the tick period is exactly len_r cycles. Stay in RUN.
    - mode_r=0: go to IDLE; done is set (registered) in the same cycle as tick.
  - stop=1 (including the cycle in which cnt_co=1): cnt_ci=0, cnt_ld=0, go to IDLE, no tick, no done, exp_cnt unchanged.
- tick and done are single-cycle registered pulses; they clear on the following edge.
- start is ignored outside IDLE; len and mode changes while busy have no effect.
- Latency:
  - start sampled at edge E: LOAD during cycle E..E+1, RUN from E+1.
  - First tick pulse: high in the cycle beginning at edge E+1+len_r.
- The counter's own reset is independent. The controller never relies on cnt_q before its own LOAD.

Test Plan:
- One-shot basic: len=5, mode=0, pulse start 1 cycle → cnt_ld high 1 cycle with cnt_d=8'hFB; cnt_ci high 5 cycles; cnt_q steps FB..FF→00; single tick and done together; busy low afterward; exp_cnt=1.
- Periodic: len=3, mode=1 → ticks exactly every 3 cycles; cnt_d=8'hFD reloads coincide with cnt_co; after 4 ticks exp_cnt=4; remain sequence 3,2,1,3,2,1.
- len=0 one-shot → cnt_d=8'h00; 256 counting cycles before done; len=1 → cnt_d=8'hFF, tick after 1 RUN cycle.
- Stop collisions: stop asserted in the same cycle as cnt_co → no tick, no done, IDLE next cycle, cnt_ci=0 that cycle. start and stop together in IDLE → stays IDLE, busy stays 0.
- Busy-time start: assert start with len=9 mid-RUN of a len=4 one-shot → ignored; done after 4 cycles; a subsequent start runs with len=9.
- Async reset: assert rst mid-RUN between clock edges → busy, cnt_ci, tick and exp_cnt drop to 0 immediately; after release, the controller stays IDLE until the next start.
